ltsm_sb_msg_router: RTL and testbench

//  Sits between the LTSM state blocks and the sideband transmitter/receiver.
//  TX path: round-robins N_REQ state-block requests onto the single sideband TX port.

---
 rtl/ltsm_sb_msg_router.sv | 131 +++++++++++++
 tb/tb_ltsm_sb_msg_router.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ltsm_sb_msg_router.sv
// LTSM sideband message router: round-robin TX arbitration of state-block
// requests onto one sideband port, plus an RX FIFO delivered to the owning block.
module ltsm_sb_msg_router #(
  parameter int N_REQ    = 4,
  parameter int RX_DEPTH = 4,
  parameter int MSG_W    = 32
) (
  input  logic                        clk_800MHz,
  input  logic                        reset,
  input  logic [N_REQ-1:0][MSG_W-1:0] tx_msg_i,
  input  logic [N_REQ-1:0]            tx_valid_i,
  output logic [N_REQ-1:0]            tx_ack_o,
  output logic [MSG_W-1:0]            sb_tx_msg_o,
  output logic                        sb_tx_valid_o,
  input  logic                        sb_tx_ready_i,
  input  logic [MSG_W-1:0]            sb_rx_msg_i,
  input  logic                        sb_rx_valid_i,
  output logic                        sb_rx_ready_o,
  input  logic [N_REQ-1:0]            rx_sel_i,
  input  logic [N_REQ-1:0]            rx_req_i,
  output logic [MSG_W-1:0]            rx_msg_o,
  output logic [N_REQ-1:0]            rx_valid_o,
  input  logic                        rx_flush_i,
  output logic                        rx_overflow_o
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW = $clog2(RX_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_t;

  tx_state_t         state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     next_grant;
  logic [GW-1:0]     cand;
  logic              any_valid;
  logic [MSG_W-1:0]  hold;

  // Nearest requester after the previous winner takes the grant.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_grant = last_grant;
    any_valid  = 1'b0;
    cand       = last_grant;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = GW'((int'(last_grant) + i) % N_REQ);
      if (!any_valid && tx_valid_i[cand]) begin
        any_valid  = 1'b1;
        next_grant = cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_800MHz) begin
    if (!reset) begin
      state      <= IDLE;
      hold       <= '0;
      grant      <= '0;
      last_grant <= GW'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          hold  <= tx_msg_i[next_grant];
          grant <= next_grant;
          state <= SEND;
        end
        SEND: if (sb_tx_ready_i) begin
          last_grant <= grant;
          state      <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign sb_tx_valid_o = (state == SEND);
  assign sb_tx_msg_o   = hold;

  // A message caught by reset is discarded, so its ack is suppressed too.
  always_comb begin
    tx_ack_o = '0;
    if (reset && state == SEND && sb_tx_ready_i) tx_ack_o[grant] = 1'b1;
  end

  // RX FIFO
  logic [MSG_W-1:0] mem [RX_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             deliver;
  logic             push;
  logic             pop;

  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign sb_rx_ready_o = !full;
  assign deliver       = !empty && $onehot(rx_sel_i);
  assign rx_valid_o    = {N_REQ{deliver}} & rx_sel_i;
  assign rx_msg_o      = mem[rd_ptr[AW-1:0]];
  assign push          = sb_rx_valid_i && !full && !rx_flush_i;
  assign pop           = |(rx_valid_o & rx_req_i);

  always_ff @(posedge clk_800MHz) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rx_overflow_o <= 1'b0;
    end else begin
      if (sb_rx_valid_i && full) rx_overflow_o <= 1'b1;
      if (rx_flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // NOTE: storage is not reset; empty pointers already mask stale entries.
  always_ff @(posedge clk_800MHz) begin
    if (reset && push) mem[wr_ptr[AW-1:0]] <= sb_rx_msg_i;
  end

endmodule

// File: tb/tb_ltsm_sb_msg_router.sv
// Directed bench for ltsm_sb_msg_router: TX arbitration/handshake and RX FIFO.
module tb_ltsm_sb_msg_router;

  localparam int N  = 4;
  localparam int MW = 32;

  logic              clk_800MHz;
  logic              reset;
  logic [N-1:0][MW-1:0] tx_msg;
  logic [N-1:0]      tx_valid;
  logic [N-1:0]      tx_ack;
  logic [MW-1:0]     sb_tx_msg;
  logic              sb_tx_valid;
  logic              sb_tx_ready;
  logic [MW-1:0]     sb_rx_msg;
  logic              sb_rx_valid;
  logic              sb_rx_ready;
  logic [N-1:0]      rx_sel;
  logic [N-1:0]      rx_req;
  logic [MW-1:0]     rx_msg;
  logic [N-1:0]      rx_valid;
  logic              rx_flush;
  logic              rx_overflow;

  int total = 0;
  int bad   = 0;

  ltsm_sb_msg_router #(.N_REQ(N), .RX_DEPTH(4), .MSG_W(MW)) dut (
    .clk_800MHz   (clk_800MHz),
    .reset        (reset),
    .tx_msg_i     (tx_msg),
    .tx_valid_i   (tx_valid),
    .tx_ack_o     (tx_ack),
    .sb_tx_msg_o  (sb_tx_msg),
    .sb_tx_valid_o(sb_tx_valid),
    .sb_tx_ready_i(sb_tx_ready),
    .sb_rx_msg_i  (sb_rx_msg),
    .sb_rx_valid_i(sb_rx_valid),
    .sb_rx_ready_o(sb_rx_ready),
    .rx_sel_i     (rx_sel),
    .rx_req_i     (rx_req),
    .rx_msg_o     (rx_msg),
    .rx_valid_o   (rx_valid),
    .rx_flush_i   (rx_flush),
    .rx_overflow_o(rx_overflow)
  );

  initial clk_800MHz = 1'b0;
  always #5 clk_800MHz = ~clk_800MHz;

  typedef struct {
    logic [N-1:0]  sel;
    logic [N-1:0]  req;
    logic [N-1:0]  exp_valid;
    logic          chk_head;
    logic [MW-1:0] exp_head;
  } rx_vec_t;

  rx_vec_t      vecs [8];
  logic [N-1:0] exp_ack;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_800MHz);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < N; k++) tx_msg[k] = 32'hA000_0000 | (32'(k + 1) << 4);
    tx_valid    = '0;
    sb_tx_ready = 1'b0;
    sb_rx_msg   = '0;
    sb_rx_valid = 1'b0;
    rx_sel      = '0;
    rx_req      = '0;
    rx_flush    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    check("rst_ack", 64'(tx_ack), 0);
    check("rst_tx_valid", 64'(sb_tx_valid), 0);
    check("rst_tx_msg", 64'(sb_tx_msg), 0);
    check("rst_rx_ready", 64'(sb_rx_ready), 1);
    check("rst_overflow", 64'(rx_overflow), 0);
    reset = 1'b1;
  endtask

  task automatic push_msg(input logic [MW-1:0] m);
    sb_rx_valid = 1'b1;
    sb_rx_msg   = m;
    tick();
    sb_rx_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'b0000, 4'b1111, 4'b0000, 1'b1, 32'h11};
    vecs[1] = '{4'b0010, 4'b0001, 4'b0010, 1'b1, 32'h11};
    vecs[2] = '{4'b0011, 4'b0011, 4'b0000, 1'b1, 32'h11};
    vecs[3] = '{4'b0010, 4'b0010, 4'b0010, 1'b1, 32'h11};
    vecs[4] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 32'h22};
    vecs[5] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 32'h22};
    vecs[6] = '{4'b1000, 4'b1000, 4'b1000, 1'b1, 32'h33};
    vecs[7] = '{4'b1000, 4'b1000, 4'b0000, 1'b0, 32'h0};

    // Requesters 1 and 2 together: grant 1, then 2 three cycles later.
    do_reset();
    tx_valid = 4'b0110; sb_tx_ready = 1'b1;
    settle();
    check("t1_idle_valid", 64'(sb_tx_valid), 0);
    tick();
    check("t1_ack1", 64'(tx_ack), 64'b0010);
    check("t1_msg1", 64'(sb_tx_msg), 64'(tx_msg[1]));
    tick();
    tx_valid = 4'b0100;
    settle();
    check("t1_gap_ack", 64'(tx_ack), 0);
    check("t1_gap_valid", 64'(sb_tx_valid), 0);
    tick();
    check("t1_idle2_valid", 64'(sb_tx_valid), 0);
    tick();
    check("t1_ack2", 64'(tx_ack), 64'b0100);
    check("t1_msg2", 64'(sb_tx_msg), 64'(tx_msg[2]));
    tick();
    tx_valid = '0;
    tick();

    // All requesters valid: one ack every third cycle, rotating 0,1,2,3.
    do_reset();
    tx_valid = 4'b1111; sb_tx_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      settle();
      exp_ack = (c % 3 == 1) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
      check($sformatf("t2_ack_c%0d", c), 64'(tx_ack), 64'(exp_ack));
      if (c % 3 == 1)
        check($sformatf("t2_msg_c%0d", c), 64'(sb_tx_msg), 64'(tx_msg[(c / 3) % 4]));
      tick();
    end
    tx_valid = '0;
    tick();

    // Back-pressure in SEND; requester drops valid and changes its input.
    do_reset();
    tx_valid = 4'b0001;
    tick();
    tx_valid  = '0;
    tx_msg[0] = 32'hDEAD_BEEF;
    for (int c = 0; c < 10; c++) begin
      settle();
      check($sformatf("t3_valid_c%0d", c), 64'(sb_tx_valid), 1);
      check($sformatf("t3_msg_c%0d", c), 64'(sb_tx_msg), 64'hA000_0010);
      check($sformatf("t3_noack_c%0d", c), 64'(tx_ack), 0);
      tick();
    end
    sb_tx_ready = 1'b1;
    settle();
    check("t3_ack", 64'(tx_ack), 64'b0001);
    tick();
    check("t3_gap_valid", 64'(sb_tx_valid), 0);
    check("t3_gap_ack", 64'(tx_ack), 0);

    // Fill FIFO, overflow on the fifth, then drain in order.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sb_rx_valid = 1'b1;
      sb_rx_msg   = 32'h100 + 32'(i);
      settle();
      check($sformatf("t4_ready_i%0d", i), 64'(sb_rx_ready), (i < 4) ? 1 : 0);
      tick();
    end
    sb_rx_valid = 1'b0;
    settle();
    check("t4_overflow", 64'(rx_overflow), 1);
    check("t4_nosel_valid", 64'(rx_valid), 0);
    rx_sel = 4'b0001; rx_req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      settle();
      if (i == 0) check("t4_full_while_pop", 64'(sb_rx_ready), 0);
      check($sformatf("t4_valid_i%0d", i), 64'(rx_valid), 64'b0001);
      check($sformatf("t4_head_i%0d", i), 64'(rx_msg), 64'h100 + 64'(i));
      tick();
    end
    check("t4_empty_valid", 64'(rx_valid), 0);
    check("t4_ready_after", 64'(sb_rx_ready), 1);
    check("t4_overflow_sticky", 64'(rx_overflow), 1);

    // Flush wins over a same-cycle push; overflow is left alone.
    rx_sel = '0; rx_req = '0;
    push_msg(32'h55);
    push_msg(32'h66);
    rx_flush = 1'b1; sb_rx_valid = 1'b1; sb_rx_msg = 32'h77;
    tick();
    rx_flush = 1'b0; sb_rx_valid = 1'b0; rx_sel = 4'b0001;
    settle();
    check("flush_empty", 64'(rx_valid), 0);
    check("flush_overflow", 64'(rx_overflow), 1);
    rx_sel = '0;

    // Select/request table on a three-entry FIFO.
    do_reset();
    push_msg(32'h11);
    push_msg(32'h22);
    push_msg(32'h33);
    for (int v = 0; v < 8; v++) begin
      rx_sel = vecs[v].sel;
      rx_req = vecs[v].req;
      settle();
      check($sformatf("t5_valid_v%0d", v), 64'(rx_valid), 64'(vecs[v].exp_valid));
      if (vecs[v].chk_head)
        check($sformatf("t5_head_v%0d", v), 64'(rx_msg), 64'(vecs[v].exp_head));
      check($sformatf("t5_ready_v%0d", v), 64'(sb_rx_ready), 1);
      tick();
    end
    rx_sel = '0; rx_req = '0;

    // Reset while in SEND with two FIFO entries.
    do_reset();
    push_msg(32'hC1);
    push_msg(32'hC2);
    tx_valid = 4'b0001;
    tick();
    settle();
    check("t6_in_send", 64'(sb_tx_valid), 1);
    reset = 1'b0; sb_tx_ready = 1'b1;
    settle();
    check("t6_no_ack_in_reset", 64'(tx_ack), 0);
    tick();
    rx_sel = 4'b0001;
    settle();
    check("t6_tx_valid", 64'(sb_tx_valid), 0);
    check("t6_tx_msg", 64'(sb_tx_msg), 0);
    check("t6_ack", 64'(tx_ack), 0);
    check("t6_rx_valid", 64'(rx_valid), 0);
    check("t6_rx_ready", 64'(sb_rx_ready), 1);
    check("t6_overflow", 64'(rx_overflow), 0);
    reset = 1'b1; tx_valid = '0; sb_tx_ready = 1'b0;
    tick();
    check("t6_fifo_empty", 64'(rx_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
